// File: rtl/bus_pkg.sv
// Shared definitions for the instruction fetch buffer: FSM state encodings,
// the cache access size code, the PC step and the queue entry layout.
package bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_FULL  = 2'd2
  } fetchState_t;

  localparam logic [1:0]  SIZE_WORD = 2'b10;
  localparam logic [31:0] PC_INC    = 32'd4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] data;
  } fetchEntry_t;

  // Word-align an address by clearing the two byte-offset bits.
  function automatic logic [31:0] alignPc(input logic [31:0] pc);
    return pc & ~32'd3;
  endfunction

endpackage

// File: rtl/ifetch_fifo.sv
// Instruction queue storage for ifetch_buf: circular buffer of {pc, word}
// entries with wrapping read/write pointers and an occupancy count.
// A flush empties the queue and takes priority over push and pop.
module ifetch_fifo
  import bus_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_flush,
  input  logic                   i_push,
  input  logic [31:0]            i_pushPc,
  input  logic [31:0]            i_pushData,
  input  logic                   i_pop,
  output logic [31:0]            o_headPc,
  output logic [31:0]            o_headData,
  output logic [$clog2(DEPTH):0] o_count,
  output logic                   o_empty,
  output logic                   o_full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  fetchEntry_t      r_mem [DEPTH];
  logic [PTR_W-1:0] r_wrPtr;
  logic [PTR_W-1:0] r_rdPtr;
  logic [CNT_W-1:0] r_count;
  logic             w_doPush;
  logic             w_doPop;

  assign o_full     = (r_count == CNT_W'(DEPTH));
  assign o_empty    = (r_count == '0);
  assign o_count    = r_count;
  assign w_doPush   = i_push && !o_full;
  assign w_doPop    = i_pop && !o_empty;
  assign o_headPc   = r_mem[r_rdPtr].pc;
  assign o_headData = r_mem[r_rdPtr].data;

  // Pointer and occupancy bookkeeping; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_doPush) r_wrPtr <= r_wrPtr + PTR_W'(1);
      if (w_doPop)  r_rdPtr <= r_rdPtr + PTR_W'(1);
      case ({w_doPush, w_doPop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry storage needs no reset; only slots covered by the count are ever read as valid.
  always_ff @(posedge clk) begin
    if (w_doPush && !i_flush) begin
      r_mem[r_wrPtr].pc   <= i_pushPc;
      r_mem[r_wrPtr].data <= i_pushData;
    end
  end

endmodule

// File: rtl/ifetch_buf.sv
// Instruction fetch buffer: issues sequential word fetches to the cache,
// queues returned words with their addresses and hands them to decode.
// A redirect flushes the queue and restarts fetching at the new address.
// Optional feature: define IFETCH_BYPASS_EN to forward a completing fetch
// straight to the decode outputs when the queue is empty.
module ifetch_buf
  import bus_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_en,
  input  logic        redir_valid,
  input  logic [31:0] redir_pc,
  output logic        cpu_valid,
  input  logic        cpu_ready,
  output logic [31:0] cpu_addr,
  output logic [1:0]  cpu_size,
  input  logic [31:0] cpu_rdata,
  output logic        ins_valid,
  input  logic        ins_ready,
  output logic [31:0] ins_data,
  output logic [31:0] ins_pc
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  fetchState_t      r_state;
  logic [31:0]      r_pc;
  logic [CNT_W-1:0] w_count;
  logic [CNT_W-1:0] w_nextCount;
  logic             w_empty;
  logic             w_full;
  logic             w_fire;
  logic             w_pending;
  logic             w_bypass;
  logic             w_push;
  logic             w_pop;
  logic [31:0]      w_headPc;
  logic [31:0]      w_headData;

  // A request is only raised while fetching, with room in the queue and no redirect.
  assign cpu_valid = (r_state == ST_FETCH) && !w_full && !redir_valid;
  assign cpu_addr  = r_pc;
  assign cpu_size  = SIZE_WORD;
  assign w_fire    = cpu_valid && cpu_ready;
  assign w_pending = cpu_valid && !cpu_ready;

`ifdef IFETCH_BYPASS_EN
  assign w_bypass = w_empty && w_fire;
`else
  assign w_bypass = 1'b0;
`endif

  assign ins_valid = !w_empty || w_bypass;
  assign ins_data  = w_bypass ? cpu_rdata : w_headData;
  assign ins_pc    = w_bypass ? cpu_addr  : w_headPc;
  assign w_pop     = !w_empty && ins_ready;
  assign w_push    = w_fire && !(w_bypass && ins_ready);

  // Occupancy after this edge, used to detect the queue filling up.
  always_comb begin
    w_nextCount = w_count;
    case ({w_push, w_pop})
      2'b10:   w_nextCount = w_count + CNT_W'(1);
      2'b01:   w_nextCount = w_count - CNT_W'(1);
      default: w_nextCount = w_count;
    endcase
  end

  ifetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .i_flush    (redir_valid),
    .i_push     (w_push),
    .i_pushPc   (r_pc),
    .i_pushData (cpu_rdata),
    .i_pop      (w_pop),
    .o_headPc   (w_headPc),
    .o_headData (w_headData),
    .o_count    (w_count),
    .o_empty    (w_empty),
    .o_full     (w_full)
  );

  // Fetch FSM and PC: redirect wins, otherwise idle when disabled with nothing outstanding.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_pc    <= RESET_PC;
    end else if (redir_valid) begin
      r_pc    <= alignPc(redir_pc);
      r_state <= fetch_en ? ST_FETCH : ST_IDLE;
    end else begin
      if (w_fire) r_pc <= r_pc + PC_INC;
      if (!fetch_en && !w_pending) begin
        r_state <= ST_IDLE;
      end else begin
        case (r_state)
          ST_IDLE:  if (fetch_en) r_state <= ST_FETCH;
          ST_FETCH: if (w_nextCount == CNT_W'(DEPTH)) r_state <= ST_FULL;
          ST_FULL:  if (w_pop) r_state <= ST_FETCH;
          default:  r_state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ifetch_buf.sv
// Testbench for ifetch_buf: directed scenarios followed by randomized traffic,
// checked by a scoreboard monitor against a queue-based model of the buffer.
module tb_ifetch_buf;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
`ifdef IFETCH_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] data;
  } tbEntry_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fetch_en = 1'b0;
  logic        redir_valid = 1'b0;
  logic [31:0] redir_pc = '0;
  logic        cpu_valid;
  logic        cpu_ready = 1'b0;
  logic [31:0] cpu_addr;
  logic [1:0]  cpu_size;
  logic [31:0] cpu_rdata = '0;
  logic        ins_valid;
  logic        ins_ready = 1'b0;
  logic [31:0] ins_data;
  logic [31:0] ins_pc;

  int          checkCount = 0;
  int          passCount  = 0;
  int          obsFires   = 0;
  logic [31:0] salt       = 32'h5A3C_96E1;

  tbEntry_t    sbq[$];
  logic [31:0] modelPc = RESET_PC;
  logic        active  = 1'b0;
  logic        expCv, expFire, expBypass, expIv;
  tbEntry_t    expHead;

  ifetch_buf #(
    .DEPTH    (DEPTH),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .fetch_en    (fetch_en),
    .redir_valid (redir_valid),
    .redir_pc    (redir_pc),
    .cpu_valid   (cpu_valid),
    .cpu_ready   (cpu_ready),
    .cpu_addr    (cpu_addr),
    .cpu_size    (cpu_size),
    .cpu_rdata   (cpu_rdata),
    .ins_valid   (ins_valid),
    .ins_ready   (ins_ready),
    .ins_data    (ins_data),
    .ins_pc      (ins_pc)
  );

  always #5 clk = ~clk;

  // Cache memory contents: a fixed scramble of the address.
  function automatic logic [31:0] memWord(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ salt;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checkCount++;
    if (act !== exp) $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    else passCount++;
  endtask

  task automatic applyStimulus(input logic fe, input logic rv, input logic [31:0] rpc,
                               input logic cr, input logic ir);
    @(negedge clk);
    fetch_en    = fe;
    redir_valid = rv;
    redir_pc    = rpc;
    cpu_ready   = cr;
    ins_ready   = ir;
  endtask

  task automatic doReset();
    @(negedge clk);
    rst = 1'b1;
    fetch_en = 1'b0; redir_valid = 1'b0; cpu_ready = 1'b0; ins_ready = 1'b0;
    #3;
    checkOutput("resetCpuValid", cpu_valid, 0);
    checkOutput("resetInsValid", ins_valid, 0);
    checkOutput("resetCpuAddr", cpu_addr, RESET_PC);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Cache model: returns the word for the current address, settled after the edge.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      cpu_rdata = memWord(cpu_addr);
    end
  end

  // Scoreboard monitor: samples just before each rising edge and advances the model.
  initial begin
    forever begin
      @(negedge clk);
      #4;
      if (rst) begin
        sbq.delete();
        modelPc = RESET_PC;
        active  = 1'b0;
        checkOutput("rstCpuValid", cpu_valid, 0);
        checkOutput("rstInsValid", ins_valid, 0);
      end else begin
        if (cpu_valid && cpu_ready) obsFires++;
        expCv     = active && (sbq.size() < DEPTH) && !redir_valid;
        expFire   = expCv && cpu_ready;
        expBypass = BYP && (sbq.size() == 0) && expFire;
        expIv     = (sbq.size() != 0) || expBypass;
        checkOutput("cpuValid", cpu_valid, expCv);
        checkOutput("cpuSize", cpu_size, 2'b10);
        if (expCv) checkOutput("cpuAddr", cpu_addr, modelPc);
        checkOutput("insValid", ins_valid, expIv);
        if (expIv) begin
          expHead = expBypass ? tbEntry_t'{modelPc, memWord(modelPc)} : sbq[0];
          checkOutput("insPc", ins_pc, expHead.pc);
          checkOutput("insData", ins_data, expHead.data);
        end
        if (redir_valid) begin
          sbq.delete();
          modelPc = redir_pc & ~32'd3;
        end else begin
          if (expIv && ins_ready && !expBypass) void'(sbq.pop_front());
          if (expFire && !(expBypass && ins_ready)) sbq.push_back(tbEntry_t'{modelPc, memWord(modelPc)});
          if (expFire) modelPc = modelPc + 32'd4;
        end
        active = fetch_en || (expCv && !cpu_ready);
      end
    end
  end

  // Directed scenarios, then randomized traffic with one mid-run reset.
  initial begin
    int base;
    salt = $urandom;
    doReset();

    // Streaming fetch from reset, then a cache stall at 0x10.
    base = obsFires;
    for (int k = 0; k < 20 && (obsFires - base) < 4; k++) begin
      applyStimulus(1, 0, 0, 1, 1);
      #6;
    end
    checkOutput("streamFires", obsFires - base, 4);
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1, 0, 0, 0, 0);
      #3;
      checkOutput("stallAddr", cpu_addr, 32'h10);
      checkOutput("stallValid", cpu_valid, 1);
      checkOutput("stallFires", obsFires - base, 4);
      checkOutput("stallInsValid", ins_valid, BYP ? 0 : 1);
    end

    // Fill the queue with decode stalled, then free one slot.
    doReset();
    base = obsFires;
    repeat (10) applyStimulus(1, 0, 0, 1, 0);
    #3;
    checkOutput("fullFires", obsFires - base, DEPTH);
    checkOutput("fullCpuValid", cpu_valid, 0);
    checkOutput("fullInsValid", ins_valid, 1);
    applyStimulus(1, 0, 0, 1, 1);
    repeat (6) applyStimulus(1, 0, 0, 1, 0);
    #3;
    checkOutput("onePopFires", obsFires - base, DEPTH + 1);
    checkOutput("onePopCpuValid", cpu_valid, 0);

    // Redirect to an unaligned address while the cache is returning data.
    repeat (3) applyStimulus(1, 0, 0, 1, 1);
    applyStimulus(1, 1, 32'h103, 1, 1);
    #3;
    checkOutput("redirCpuValid", cpu_valid, 0);
    applyStimulus(1, 0, 0, 0, 1);
    #3;
    checkOutput("redirEmpty", ins_valid, 0);
    checkOutput("redirAddr", cpu_addr, 32'h100);
    checkOutput("redirValid", cpu_valid, 1);

    // PC wrap at the top of the address space.
    applyStimulus(1, 1, 32'hFFFF_FFFE, 1, 1);
    applyStimulus(1, 0, 0, 1, 1);
    #3;
    checkOutput("wrapAddrTop", cpu_addr, 32'hFFFF_FFFC);
    applyStimulus(1, 0, 0, 1, 1);
    #3;
    checkOutput("wrapAddrZero", cpu_addr, 32'h0);

    // Empty queue with a completing fetch: forwarded only in the bypass build.
    doReset();
    applyStimulus(1, 0, 0, 1, 1);
    applyStimulus(1, 0, 0, 1, 1);
    #3;
    checkOutput("bypassInsValid", ins_valid, BYP);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      applyStimulus($urandom_range(0, 9) != 0, $urandom_range(0, 19) == 0, $urandom,
                    $urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1);
      rst = (i == 200);
    end
    applyStimulus(0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    #6;
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
